// File: rtl/led_pkg.sv
// Shared types and constants for the 4-LED flow sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    localparam int SPEED_W = 2;
    localparam int LED_N   = 4;

    typedef enum logic [1:0] {
        MODE_FLOW_L   = 2'd0,
        MODE_FLOW_R   = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_e;

    localparam logic [LED_N-1:0] SEED_FLOW  = 4'b0001;
    localparam logic [LED_N-1:0] SEED_BLINK = 4'b1111;
    localparam logic [LED_N-1:0] PAT_TOP    = 4'b1000;
    localparam logic [LED_N-1:0] PAT_BOT    = 4'b0001;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

    function automatic logic [LED_N-1:0] seed_of(input mode_e m);
        return (m == MODE_BLINK) ? SEED_BLINK : SEED_FLOW;
    endfunction

    function automatic logic is_onehot(input logic [LED_N-1:0] p);
        return $onehot(p);
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step tick generator: counts CNT_BASE >> speed clocks per step while run_en is high.
// Latency: step is combinational on the terminal count; the counter wraps on the same edge.
// Backpressure: run_en low holds the count; clr zeroes it and suppresses the tick.
module led_step_timer
    import led_pkg::*;
#(
    parameter int               CNT_W    = 26,
    parameter logic [CNT_W-1:0] CNT_BASE = 26'd50000000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run_en,
    input  logic               clr,
    input  logic [SPEED_W-1:0] speed,
    output logic               step
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period;
    logic             wrap;

    assign period = CNT_BASE >> speed;
    assign wrap   = run_en && (cnt_q == period - CNT_ONE);
    // A key press restarts the period, so it also swallows a coincident tick.
    assign step   = wrap && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || wrap) begin
            cnt_d = '0;
        end else if (run_en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// 4-LED pattern sequencer: key pulses pick mode/speed, internal tick advances the pattern.
// Latency: led_o changes one cycle after step_o or a mode key; optional PWM gate under LED_PWM_EN.
// Backpressure: none; run_en low freezes counter and pattern while keys are still taken.
module led_flow_ctrl
    import led_pkg::*;
#(
    parameter int               CNT_W          = 26,
    parameter logic [CNT_W-1:0] CNT_BASE       = 26'd50000000,
    parameter bit               LED_ACTIVE_LOW = 1'b1
`ifdef LED_PWM_EN
    ,
    parameter int                  PWM_BITS = 4,
    parameter logic [PWM_BITS-1:0] PWM_DUTY = 4'd4
`endif
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               mode_key,
    input  logic               speed_key,
    input  logic               run_en,
    output logic [LED_N-1:0]   led_o,
    output logic [1:0]         mode_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic               step_o
);

    mode_e              mode_q,    mode_d;
    logic [SPEED_W-1:0] speed_q,   speed_d;
    logic [LED_N-1:0]   pattern_q, pattern_d;
    logic               dir_q,     dir_d;
    logic               step;
    logic               clr;
    logic [LED_N-1:0]   disp;

    assign clr = mode_key || speed_key;

    led_step_timer #(
        .CNT_W    (CNT_W),
        .CNT_BASE (CNT_BASE)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .run_en (run_en),
        .clr    (clr),
        .speed  (speed_q),
        .step   (step)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q <= MODE_FLOW_L;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_key) begin
            mode_d = next_mode(mode_q);
        end
    end

    always_comb begin
        speed_d = speed_q;
        if (speed_key) begin
            speed_d = speed_q + 2'd1;
        end
    end

    // Pattern datapath: a mode key reseeds and takes priority over any tick.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        if (mode_key) begin
            pattern_d = seed_of(mode_d);
            dir_d     = DIR_LEFT;
        end else if (step) begin
            if (mode_q == MODE_BLINK) begin
                pattern_d = ~pattern_q;
            end else if (!is_onehot(pattern_q)) begin
                pattern_d = SEED_FLOW;
                dir_d     = DIR_LEFT;
            end else begin
                case (mode_q)
                    MODE_FLOW_L: pattern_d = {pattern_q[2:0], pattern_q[3]};
                    MODE_FLOW_R: pattern_d = {pattern_q[0], pattern_q[3:1]};
                    default: begin
                        if (pattern_q == PAT_TOP) begin
                            dir_d     = DIR_RIGHT;
                            pattern_d = pattern_q >> 1;
                        end else if (pattern_q == PAT_BOT) begin
                            dir_d     = DIR_LEFT;
                            pattern_d = pattern_q << 1;
                        end else if (dir_q == DIR_LEFT) begin
                            pattern_d = pattern_q << 1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            speed_q   <= '0;
            pattern_q <= SEED_FLOW;
            dir_q     <= DIR_LEFT;
        end else begin
            speed_q   <= speed_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_lit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    assign pwm_lit = (pwm_cnt_q < PWM_DUTY);
    assign disp    = pattern_q & {LED_N{pwm_lit}};
`else
    assign disp = pattern_q;
`endif

    assign led_o   = LED_ACTIVE_LOW ? ~disp : disp;
    assign mode_o  = mode_q;
    assign speed_o = speed_q;
    assign step_o  = step;

endmodule
